// File: rtl/mem_write_monitor_pkg.sv
// rtl/mem_write_monitor_pkg.sv - shared verdict states and default program-check constants
package mem_write_monitor_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PASS = 2'd1,
    ST_FAIL = 2'd2
  } state_e;

  localparam logic [31:0] DEF_PASS_ADDR  = 32'd84;
  localparam logic [31:0] DEF_PASS_DATA  = 32'd7;
  localparam logic [31:0] DEF_ALLOW_ADDR = 32'd80;

  localparam int ENTRY_W = 64;

  function automatic logic [ENTRY_W-1:0] pack_entry(input logic [31:0] addr,
                                                    input logic [31:0] data);
    return {addr, data};
  endfunction

endpackage

// File: rtl/mem_write_monitor_if.sv
// rtl/mem_write_monitor_if.sv - CPU store bus in, logged-store drain stream out
interface mem_write_monitor_if;

  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_data;

  modport master (
    output memwrite,
    output dataadr,
    output writedata,
    output out_ready,
    input  out_valid,
    input  out_addr,
    input  out_data
  );

  modport slave (
    input  memwrite,
    input  dataadr,
    input  writedata,
    input  out_ready,
    output out_valid,
    output out_addr,
    output out_data
  );

endinterface

// File: rtl/mem_write_monitor_store_fifo.sv
// rtl/mem_write_monitor_store_fifo.sv - synchronous store FIFO with registered head entry
module store_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         full,
  input  logic         pop_req,
  output logic         popping,
  output logic         valid,
  output logic [W-1:0] dout
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, rd_q, wr_n, rd_n;
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] head_q, head_n;
  logic         valid_q;

  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign popping = valid_q && pop_req;
  assign wr_n    = wr_q + {{AW{1'b0}}, push};
  assign rd_n    = rd_q + {{AW{1'b0}}, popping};

  // The next head is either an older stored entry or, when the FIFO drains
  // down to the slot being written right now, the incoming store itself.
  always_comb begin
    head_n = head_q;
    if (rd_n == wr_q) begin
      if (push) begin
        head_n = din;
      end
    end else begin
      head_n = mem[rd_n[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      valid_q <= 1'b0;
      head_q  <= '0;
    end else begin
      wr_q    <= wr_n;
      rd_q    <= rd_n;
      valid_q <= (wr_n != rd_n);
      head_q  <= head_n;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_q[AW-1:0]] <= din;
    end
  end

  assign valid = valid_q;
  assign dout  = head_q;

endmodule

// File: rtl/mem_write_monitor.sv
// rtl/mem_write_monitor.sv - logs CPU stores into a FIFO and judges pass/fail in hardware
module mem_write_monitor
  import mem_write_monitor_pkg::*;
#(
  parameter int          DEPTH      = 8,
  parameter logic [31:0] PASS_ADDR  = DEF_PASS_ADDR,
  parameter logic [31:0] PASS_DATA  = DEF_PASS_DATA,
  parameter logic [31:0] ALLOW_ADDR = DEF_ALLOW_ADDR,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  mem_write_monitor_if.slave bus,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             overflow,
  output logic [CNT_W-1:0] store_count
);

  state_e               state_q, state_n;
  logic                 observed;
  logic                 push;
  logic                 fifo_full;
  logic                 fifo_popping;
  logic [ENTRY_W-1:0]   head;

  assign observed = bus.memwrite && (state_q == ST_RUN);
  // A full FIFO still accepts the store when the head leaves on the same edge.
  assign push     = observed && (!fifo_full || fifo_popping);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = state_q;
    if (observed) begin
      if (bus.dataadr == PASS_ADDR) begin
        state_n = (bus.writedata == PASS_DATA) ? ST_PASS : ST_FAIL;
      end else if (bus.dataadr != ALLOW_ADDR) begin
        state_n = ST_FAIL;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      store_count <= '0;
      overflow    <= 1'b0;
    end else begin
      if (observed && (store_count != {CNT_W{1'b1}})) begin
        store_count <= store_count + 1'b1;
      end
      if (observed && !push) begin
        overflow <= 1'b1;
      end
    end
  end

  store_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_store_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .din     (pack_entry(bus.dataadr, bus.writedata)),
    .full    (fifo_full),
    .pop_req (bus.out_ready),
    .popping (fifo_popping),
    .valid   (bus.out_valid),
    .dout    (head)
  );

  assign bus.out_addr = head[63:32];
  assign bus.out_data = head[31:0];

  assign pass = (state_q == ST_PASS);
  assign fail = (state_q == ST_FAIL);
  assign done = pass || fail;

endmodule

// File: tb/tb_mem_write_monitor.sv
// tb/tb_mem_write_monitor.sv - randomized and directed bench for mem_write_monitor
module tb_mem_write_monitor;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_write_monitor_if bus();
  logic             done, pass, fail, overflow;
  logic [CNT_W-1:0] store_count;

  mem_write_monitor #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .done        (done),
    .pass        (pass),
    .fail        (fail),
    .overflow    (overflow),
    .store_count (store_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference: a list of logged stores, a count, a sticky drop flag and a verdict (0 run, 1 pass, 2 fail).
  logic [63:0] m_q[$];
  logic [63:0] m_drained[$];
  logic [63:0] dut_drained[$];
  int          m_cnt;
  bit          m_ovf;
  int          m_verdict;

  task automatic clear_model();
    m_q.delete();
    m_drained.delete();
    dut_drained.delete();
    m_cnt = 0;
    m_ovf = 0;
    m_verdict = 0;
  endtask

  task automatic do_reset();
    bus.memwrite = 0; bus.dataadr = 0; bus.writedata = 0; bus.out_ready = 0;
    reset = 0;
    @(posedge clk); #1;
    reset = 1;
    clear_model();
  endtask

  // One clock: apply inputs, note what is drained, then advance the reference.
  task automatic drive(input logic mw, input logic [31:0] a, input logic [31:0] d, input logic rdy);
    bit m_pop;
    int sz;
    bus.memwrite = mw; bus.dataadr = a; bus.writedata = d; bus.out_ready = rdy;
    if (bus.out_valid === 1'b1 && rdy) dut_drained.push_back({bus.out_addr, bus.out_data});
    sz = m_q.size();
    m_pop = (sz != 0) && rdy;
    if (m_pop) m_drained.push_back(m_q[0]);
    @(posedge clk); #1;
    if (m_pop) void'(m_q.pop_front());
    if (m_verdict == 0 && mw) begin
      if (m_cnt < CNT_MAX) m_cnt++;
      if (sz < DEPTH || m_pop) m_q.push_back({a, d});
      else m_ovf = 1;
      if (a == 32'd84) m_verdict = (d == 32'd7) ? 1 : 2;
      else if (a != 32'd80) m_verdict = 2;
    end
  endtask

  task automatic test_reset();
    reset = 0;
    bus.memwrite = 1; bus.dataadr = 84; bus.writedata = 7; bus.out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
    checks++; if ({bus.out_addr, bus.out_data} !== 64'd0) begin errors++; $display("FAIL reset_head got %h want 0", {bus.out_addr, bus.out_data}); end
    checks++; if ({done, pass, fail, overflow} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b want 0000", {done, pass, fail, overflow}); end
    checks++; if (store_count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", store_count); end
    do_reset();
  endtask

  task automatic test_pass_trace();
    logic [63:0] exp [3];
    exp[0] = {32'd80, 32'd5}; exp[1] = {32'd80, 32'd12}; exp[2] = {32'd84, 32'd7};
    do_reset();
    drive(1, 80, 5, 1);
    drive(1, 80, 12, 1);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL trace_done_early got %b want 0", done); end
    drive(1, 84, 7, 1);
    checks++; if ({pass, done, fail} !== 3'b110) begin errors++; $display("FAIL trace_verdict got pdf=%b want 110", {pass, done, fail}); end
    checks++; if (store_count !== 4'd3) begin errors++; $display("FAIL trace_count got %0d want 3", store_count); end
    repeat (3) drive(0, 0, 0, 1);
    checks++; if (dut_drained.size() != 3) begin errors++; $display("FAIL trace_drain_len got %0d want 3", dut_drained.size()); end
    for (int i = 0; i < 3 && i < dut_drained.size(); i++) begin
      checks++; if (dut_drained[i] !== exp[i]) begin errors++; $display("FAIL trace_entry%0d got %h want %h", i, dut_drained[i], exp[i]); end
    end
  endtask

  task automatic test_wrong_data();
    do_reset();
    drive(1, 84, 6, 0);
    checks++; if ({fail, done, pass} !== 3'b110) begin errors++; $display("FAIL wrong_verdict got fdp=%b want 110", {fail, done, pass}); end
    drive(1, 80, 1, 1);
    repeat (3) drive(0, 0, 0, 1);
    checks++; if (store_count !== 4'd1) begin errors++; $display("FAIL wrong_count got %0d want 1", store_count); end
    checks++; if (dut_drained.size() != 1) begin errors++; $display("FAIL wrong_drain_len got %0d want 1", dut_drained.size()); end
    else begin
      checks++; if (dut_drained[0] !== {32'd84, 32'd6}) begin errors++; $display("FAIL wrong_entry got %h want %h", dut_drained[0], {32'd84, 32'd6}); end
    end
  endtask

  task automatic test_illegal_addr();
    do_reset();
    drive(1, 88, 7, 1);
    checks++; if ({fail, done, pass} !== 3'b110) begin errors++; $display("FAIL illegal_verdict got fdp=%b want 110", {fail, done, pass}); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 9; i++) drive(1, 80, i, 0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", overflow); end
    checks++; if (store_count !== 4'd9) begin errors++; $display("FAIL ovf_count got %0d want 9", store_count); end
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0);
      checks++;
      if (bus.out_valid !== 1'b1 || {bus.out_addr, bus.out_data} !== {32'd80, 32'd1}) begin
        errors++; $display("FAIL ovf_stall%0d got v=%b %h want v=1 %h", k, bus.out_valid, {bus.out_addr, bus.out_data}, {32'd80, 32'd1});
      end
    end
    repeat (10) drive(0, 0, 0, 1);
    checks++; if (dut_drained.size() != 8) begin errors++; $display("FAIL ovf_drain_len got %0d want 8", dut_drained.size()); end
    for (int i = 0; i < 8 && i < dut_drained.size(); i++) begin
      checks++; if (dut_drained[i] !== {32'd80, 32'(i + 1)}) begin errors++; $display("FAIL ovf_entry%0d got %h want %h", i, dut_drained[i], {32'd80, 32'(i + 1)}); end
    end
    checks++; if (bus.out_valid !== 1'b0 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_end got v=%b ovf=%b want v=0 ovf=1", bus.out_valid, overflow); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 8; i++) drive(1, 80, 32'h10 + i, 0);
    drive(1, 80, 32'hAA, 1);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpp_ovf got %b want 0", overflow); end
    checks++; if (store_count !== 4'd9) begin errors++; $display("FAIL fullpp_count got %0d want 9", store_count); end
    repeat (12) drive(0, 0, 0, 1);
    checks++; if (dut_drained.size() != 9) begin errors++; $display("FAIL fullpp_drain_len got %0d want 9", dut_drained.size()); end
    else begin
      checks++; if (dut_drained[0] !== {32'd80, 32'h10}) begin errors++; $display("FAIL fullpp_first got %h want %h", dut_drained[0], {32'd80, 32'h10}); end
      checks++; if (dut_drained[8] !== {32'd80, 32'hAA}) begin errors++; $display("FAIL fullpp_last got %h want %h", dut_drained[8], {32'd80, 32'hAA}); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) drive(1, 80, i, 0);
    checks++; if (bus.out_valid !== 1'b1 || store_count !== 4'd3) begin errors++; $display("FAIL areset_pre got v=%b cnt=%0d want v=1 cnt=3", bus.out_valid, store_count); end
    #2 reset = 0;
    #1;
    checks++; if (bus.out_valid !== 1'b0 || store_count !== '0 || done !== 1'b0) begin
      errors++; $display("FAIL areset_drop got v=%b cnt=%0d done=%b want 0 0 0", bus.out_valid, store_count, done);
    end
    @(posedge clk); #1;
    reset = 1;
    clear_model();
    drive(1, 84, 7, 0);
    checks++; if (pass !== 1'b1 || fail !== 1'b0) begin errors++; $display("FAIL areset_pass got p=%b f=%b want 1 0", pass, fail); end
    checks++; if ({bus.out_addr, bus.out_data} !== {32'd84, 32'd7} || store_count !== 4'd1) begin
      errors++; $display("FAIL areset_head got %h cnt=%0d want %h cnt=1", {bus.out_addr, bus.out_data}, store_count, {32'd84, 32'd7});
    end
  endtask

  task automatic test_random();
    for (int ep = 0; ep < 6; ep++) begin
      int mode;
      mode = ep % 3;
      do_reset();
      for (int c = 0; c < 200; c++) begin
        logic        mw, rdy;
        logic [31:0] a, d;
        int          r;
        mw  = ($urandom_range(0, 99) < 60);
        rdy = ($urandom_range(0, 99) < (mode == 0 ? 25 : (mode == 1 ? 50 : 80)));
        d   = $urandom;
        r   = $urandom_range(0, 999);
        if (mode == 0 || r < 940) a = 32'd80;
        else if (r < 975) begin a = 32'd84; if ($urandom_range(0, 1) == 1) d = 32'd7; end
        else a = $urandom;
        drive(mw, a, d, rdy);
        checks++; if (bus.out_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL rnd_valid ep%0d c%0d got %b want %b", ep, c, bus.out_valid, m_q.size() != 0); end
        if (m_q.size() != 0) begin
          checks++; if ({bus.out_addr, bus.out_data} !== m_q[0]) begin errors++; $display("FAIL rnd_head ep%0d c%0d got %h want %h", ep, c, {bus.out_addr, bus.out_data}, m_q[0]); end
        end
        checks++; if (store_count !== CNT_W'(m_cnt)) begin errors++; $display("FAIL rnd_count ep%0d c%0d got %0d want %0d", ep, c, store_count, m_cnt); end
        checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf ep%0d c%0d got %b want %b", ep, c, overflow, m_ovf); end
        checks++;
        if ({pass, fail, done} !== {m_verdict == 1, m_verdict == 2, m_verdict != 0}) begin
          errors++; $display("FAIL rnd_verdict ep%0d c%0d got pfd=%b want verdict %0d", ep, c, {pass, fail, done}, m_verdict);
        end
      end
      checks++; if (dut_drained != m_drained) begin errors++; $display("FAIL rnd_drained ep%0d got %0d entries want %0d", ep, dut_drained.size(), m_drained.size()); end
    end
  endtask

  initial begin
    test_reset();
    test_pass_trace();
    test_wrong_data();
    test_illegal_addr();
    test_overflow();
    test_full_push_pop();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
